seq_pattern_tx: RTL and testbench

Serial bit-pattern transmitter: on a start request it captures a PAT_W-bit pattern and shifts it out MSB-first, one bit per clock, repeating it a programmable number of times with an optional run of idle zero bits between repetitions. It is the driving end of the serial sequence-detection path. Its `out` feeds the `in` input of the Mealy sequence detector, giving lab benches and on-board demos a deterministic stimulus source in place of switch-driven input.

---
 rtl/seq_pattern_tx.sv | 144 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial bit-pattern transmitter, MSB-first with repeat count and idle gaps
module seq_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] reps,
    input  logic [CNT_W-1:0] gap,
    output logic             out,
    output logic             valid,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] shift_q, shift_n;
    logic [PAT_W-1:0] pat_q, pat_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [CNT_W-1:0] rep_q, rep_n;
    logic [CNT_W-1:0] gap_q, gap_n;
    logic [CNT_W-1:0] gcnt_q, gcnt_n;
    logic             out_n, valid_n, frame_n, busy_n, done_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            shift_q <= '0;
            pat_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            out     <= 1'b0;
            valid   <= 1'b0;
            frame   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            pat_q   <= pat_n;
            idx_q   <= idx_n;
            rep_q   <= rep_n;
            gap_q   <= gap_n;
            gcnt_q  <= gcnt_n;
            out     <= out_n;
            valid   <= valid_n;
            frame   <= frame_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift_q;
        pat_n   = pat_q;
        idx_n   = idx_q;
        rep_n   = rep_q;
        gap_n   = gap_q;
        gcnt_n  = gcnt_q;
        case (state)
            IDLE: begin
                if (start) begin
                    pat_n   = pattern;
                    gap_n   = gap;
                    rep_n   = reps;
                    shift_n = pattern;
                    idx_n   = IDX_TOP;
                    state_n = (reps == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (idx_q == '0) begin
                    // rep_q counts the repetition now finishing, so 1 means last
                    rep_n = rep_q - CNT_W'(1);
                    if (rep_q == CNT_W'(1)) begin
                        state_n = DONE;
                    end else if (gap_q == '0) begin
                        shift_n = pat_q;
                        idx_n   = IDX_TOP;
                    end else begin
                        state_n = GAP;
                        gcnt_n  = gap_q;
                    end
                end else begin
                    shift_n = shift_q << 1;
                    idx_n   = idx_q - IDX_W'(1);
                end
            end
            GAP: begin
                if (gcnt_q == CNT_W'(1)) begin
                    state_n = SEND;
                    shift_n = pat_q;
                    idx_n   = IDX_TOP;
                    gcnt_n  = '0;
                end else begin
                    gcnt_n = gcnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with the state.
    always_comb begin
        out_n   = 1'b0;
        valid_n = 1'b0;
        frame_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state_n)
            SEND: begin
                out_n   = shift_n[PAT_W-1];
                valid_n = 1'b1;
                frame_n = (idx_n == IDX_TOP);
                busy_n  = 1'b1;
            end
            GAP:     busy_n = 1'b1;
            DONE:    done_n = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx
module tb_seq_pattern_tx;

    localparam int P = 4;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [P-1:0] pattern = '0;
    logic [C-1:0] reps = '0;
    logic [C-1:0] gap = '0;
    logic         out, valid, frame, busy, done;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    // One entry per clock cycle: {out, valid, frame, busy, done}
    logic [4:0] expq[$];

    seq_pattern_tx #(.PAT_W(P), .CNT_W(C)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .gap     (gap),
        .out     (out),
        .valid   (valid),
        .frame   (frame),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void push_xfer(logic [P-1:0] p, int r, int g);
        for (int k = 0; k < r; k++) begin
            for (int i = P - 1; i >= 0; i--)
                expq.push_back({p[i], 1'b1, (i == P - 1), 1'b1, 1'b0});
            if (k < r - 1)
                for (int j = 0; j < g; j++) expq.push_back(5'b00010);
        end
        expq.push_back(5'b00001);
    endfunction

    always @(negedge clk) begin
        logic [4:0] e;
        if (chk_en) begin
            if (expq.size() == 0) begin
                check("model_underflow", 64'd1, 64'd0);
            end else begin
                e = expq.pop_front();
                check("outputs", {59'd0, out, valid, frame, busy, done}, {59'd0, e});
            end
        end
    end

    // Called at posedge+1; drives inputs for the current cycle and advances one clock.
    task automatic cycle_step(input bit st, input logic [P-1:0] p, input logic [C-1:0] r,
                              input logic [C-1:0] g);
        start   = st;
        pattern = p;
        reps    = r;
        gap     = g;
        if (expq.size() == 0) begin
            expq.push_back(5'b00000);
            if (st && rst) push_xfer(p, int'(r), int'(g));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_step();
        cycle_step(1'b0, P'($urandom), C'($urandom), C'($urandom));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (expq.size() != 0 && n < 3000) begin
            rand_step();
            n++;
        end
        if (expq.size() != 0) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic xfer(string name, logic [P-1:0] p, logic [C-1:0] r, logic [C-1:0] g,
                        int poke, int e_busy, int e_valid, int e_frames, int e_done,
                        logic [63:0] e_stream, bit chk_stream);
        int nb = 0, nv = 0, nf = 0, dat = 0;
        logic [63:0] s = '0;
        wait_idle();
        cycle_step(1'b1, p, r, g);
        check($sformatf("%s.model_len", name), 64'(expq.size()), 64'(e_busy + 1));
        for (int n = 1; n <= 2000; n++) begin
            if (busy) begin
                nb++;
                s = {s[62:0], out};
            end
            if (valid) nv++;
            if (frame) nf++;
            if (done) begin
                dat = n;
                break;
            end
            if (n == poke) cycle_step(1'b1, '0, r, g);
            else rand_step();
        end
        check($sformatf("%s.busy_cycles", name), 64'(nb), 64'(e_busy));
        check($sformatf("%s.valid_bits", name), 64'(nv), 64'(e_valid));
        check($sformatf("%s.frames", name), 64'(nf), 64'(e_frames));
        check($sformatf("%s.done_cycle", name), 64'(dat), 64'(e_done));
        if (chk_stream) check($sformatf("%s.stream", name), s, e_stream);
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {59'd0, out, valid, frame, busy, done}, 64'd0);
        rst    = 1'b1;
        chk_en = 1'b1;

        xfer("single", 4'b1101, 4'd1, 4'd0, 0, 4, 4, 1, 5, 64'hD, 1'b1);
        xfer("rep3_gap2", 4'b1101, 4'd3, 4'd2, 0, 16, 12, 3, 17, 64'hD34D, 1'b1);
        xfer("reps0", 4'b1101, 4'd0, 4'd3, 0, 0, 0, 0, 1, 64'h0, 1'b1);
        xfer("start_ignored", 4'b1101, 4'd1, 4'd0, 2, 4, 4, 1, 5, 64'hD, 1'b1);
        xfer("no_bubble", 4'b1001, 4'd2, 4'd0, 0, 8, 8, 2, 9, 64'h99, 1'b1);
        xfer("max_counts", 4'b1011, 4'd15, 4'd15, 0, 270, 60, 15, 271, 64'h0, 1'b0);

        // Asynchronous reset in the middle of a gap
        wait_idle();
        cycle_step(1'b1, 4'b1101, 4'd3, 4'd2);
        repeat (4) rand_step();
        check("pre_reset_gap", {59'd0, out, valid, frame, busy, done}, 64'b00010);
        #2;
        rst = 1'b0;
        expq.delete();
        expq.push_back(5'b00000);
        #1;
        check("async_reset", {59'd0, out, valid, frame, busy, done}, 64'd0);
        rand_step();
        rand_step();
        rst = 1'b1;
        xfer("after_reset", 4'b1101, 4'd1, 4'd0, 0, 4, 4, 1, 5, 64'hD, 1'b1);

        for (int i = 0; i < 400; i++)
            cycle_step($urandom_range(0, 3) == 0, P'($urandom), C'($urandom_range(0, 4)),
                       C'($urandom_range(0, 3)));
        wait_idle();
        rand_step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
